uart_rx_fifo: RTL and testbench

- Serial UART receiver with a byte FIFO; sits directly downstream of the SoC `UART_TX` pin.
- Deserialises 8N1 frames, LSB first, using 16x oversampling derived from a runtime `baud_div`.
- Buffers received bytes for a valid/ready consumer: bench scoreboard, or a bus-side peripheral wrapper on a second SoC instance.
- Reports framing errors and FIFO overruns as sticky flags.

---
 rtl/uart_rx_fifo_if.sv | 33 +++
 rtl/uart_rx_fifo.sv | 204 ++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - consumer/control bundle for the UART receiver FIFO
//
// Purpose: groups the receiver's line input, configuration, FIFO pop handshake
// and status flags so they travel as one port.
// Signals:
//   en, rx, baud_div, m_ready, err_clr   driven by the master (SoC / bench)
//   m_data, m_valid, level, full,
//   frame_err, overrun                   driven by the slave (uart_rx_fifo)
interface uart_rx_fifo_if #(
  parameter int AW = 4
);
  logic          en;
  logic          rx;
  logic [15:0]   baud_div;
  logic [7:0]    m_data;
  logic          m_valid;
  logic          m_ready;
  logic [AW:0]   level;
  logic          full;
  logic          frame_err;
  logic          overrun;
  logic          err_clr;

  modport master (
    output en, rx, baud_div, m_ready, err_clr,
    input  m_data, m_valid, level, full, frame_err, overrun
  );

  modport slave (
    input  en, rx, baud_div, m_ready, err_clr,
    output m_data, m_valid, level, full, frame_err, overrun
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver with 16x oversampling and byte FIFO
//
// Purpose: deserialises LSB-first 8N1 frames from an asynchronous rx line and
// queues the bytes for a valid/ready consumer; sticky framing/overrun flags.
// Ports:
//   HCLK     system clock
//   HRESETn  asynchronous active-low reset
//   bus      uart_rx_fifo_if.slave: en, rx, baud_div, err_clr, m_ready in;
//            m_data, m_valid, level, full, frame_err, overrun out
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic           HCLK,
  input  logic           HRESETn,
  uart_rx_fifo_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  // Line synchroniser and edge history
  logic          r_rx_meta;
  logic          r_rxs;
  logic          r_rxs_d;

  // Receiver
  state_t        r_state;
  state_t        w_state_nxt;
  logic [15:0]   r_pre;
  logic [3:0]    r_tcnt;
  logic [2:0]    r_bitcnt;
  logic [7:0]    r_shift;
  logic          w_tick;
  logic          w_shift_en;
  logic          w_push;
  logic          w_set_ferr;

  // FIFO
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;
  logic          r_frame_err;
  logic          r_overrun;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_write;
  logic          w_set_ovr;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
      r_rxs_d   <= 1'b1;
    end else begin
      r_rx_meta <= bus.rx;
      r_rxs     <= r_rx_meta;
      r_rxs_d   <= r_rxs;
    end
  end

  // Prescaler is parked at 0 in IDLE so the first tick lands baud_div+1
  // cycles after the start edge was seen.
  assign w_tick = (r_state != S_IDLE) && (r_pre == bus.baud_div);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_en  = 1'b0;
    w_push      = 1'b0;
    w_set_ferr  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.en && r_rxs_d && !r_rxs) begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        // Mid-start-bit check rejects glitches shorter than half a bit
        if (w_tick && r_tcnt == 4'd7) begin
          w_state_nxt = r_rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_tick && r_tcnt == 4'd15) begin
          w_shift_en = 1'b1;
          if (r_bitcnt == 3'd7) begin
            w_state_nxt = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (w_tick && r_tcnt == 4'd15) begin
          w_push      = r_rxs;
          w_set_ferr  = !r_rxs;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Disable aborts the frame; the partial byte is never pushed
    if (!bus.en) begin
      w_state_nxt = S_IDLE;
      w_shift_en  = 1'b0;
      w_push      = 1'b0;
      w_set_ferr  = 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_pre    <= 16'd0;
      r_tcnt   <= 4'd0;
      r_bitcnt <= 3'd0;
      r_shift  <= 8'd0;
    end else if (r_state == S_IDLE) begin
      r_pre    <= 16'd0;
      r_tcnt   <= 4'd0;
      r_bitcnt <= 3'd0;
    end else begin
      r_pre <= w_tick ? 16'd0 : r_pre + 16'd1;
      if (r_state == S_START && w_state_nxt == S_DATA) begin
        r_tcnt <= 4'd0;
      end else if (w_tick) begin
        r_tcnt <= r_tcnt + 4'd1;
      end
      if (w_shift_en) begin
        // LSB arrives first, so after eight right-shifts it sits in bit 0
        r_shift  <= {r_rxs, r_shift[7:1]};
        r_bitcnt <= r_bitcnt + 3'd1;
      end
    end
  end

  assign w_empty   = (r_level == '0);
  assign w_full    = (r_level == LVL_FULL);
  assign w_pop     = !w_empty && bus.m_ready;
  // A pop in the same cycle frees the slot the full-FIFO push needs
  assign w_write   = w_push && (!w_full || w_pop);
  assign w_set_ovr = w_push && w_full && !w_pop;

  always_ff @(posedge HCLK) begin
    if (w_write) begin
      r_mem[r_wptr] <= r_shift;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_write) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_write && !w_pop) begin
        r_level <= r_level + 1'b1;
      end else if (w_pop && !w_write) begin
        r_level <= r_level - 1'b1;
      end
      // Set has priority over clear
      if (w_set_ferr) begin
        r_frame_err <= 1'b1;
      end else if (bus.err_clr) begin
        r_frame_err <= 1'b0;
      end
      if (w_set_ovr) begin
        r_overrun <= 1'b1;
      end else if (bus.err_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  // Head is forced to 0 while empty so reset leaves m_data at 0
  assign bus.m_data    = w_empty ? 8'h00 : r_mem[r_rptr];
  assign bus.m_valid   = !w_empty;
  assign bus.level     = r_level;
  assign bus.full      = w_full;
  assign bus.frame_err = r_frame_err;
  assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed table-driven bench for uart_rx_fifo
module tb_uart_rx_fifo;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  uart_rx_fifo_if #(.AW(4)) bus ();

  uart_rx_fifo #(.DEPTH(16), .AW(4)) dut (
    .HCLK    (clk),
    .HRESETn (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic        stop;
    logic [15:0] div;
    logic        exp_valid;
    logic        exp_ferr;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic [15:0] div);
    int bt;
    bt = 16 * (int'(div) + 1);
    bus.baud_div = div;
    bus.rx = 1'b0;
    wait_clks(bt);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      wait_clks(bt);
    end
    bus.rx = stop;
    wait_clks(bt);
    bus.rx = 1'b1;
    wait_clks(bt);
  endtask

  task automatic pop_one();
    bus.m_ready = 1'b1;
    @(negedge clk);
    bus.m_ready = 1'b0;
  endtask

  task automatic clr_err();
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    bus.en       = 1'b1;
    bus.rx       = 1'b1;
    bus.baud_div = 16'd0;
    bus.m_ready  = 1'b0;
    bus.err_clr  = 1'b0;
    rst_n        = 1'b0;

    vecs[0] = '{data: 8'h55, stop: 1'b1, div: 16'd0, exp_valid: 1'b1, exp_ferr: 1'b0};
    vecs[1] = '{data: 8'hA5, stop: 1'b0, div: 16'd0, exp_valid: 1'b0, exp_ferr: 1'b1};
    vecs[2] = '{data: 8'h3C, stop: 1'b1, div: 16'd2, exp_valid: 1'b1, exp_ferr: 1'b0};
    vecs[3] = '{data: 8'hFF, stop: 1'b1, div: 16'd1, exp_valid: 1'b1, exp_ferr: 1'b0};
    vecs[4] = '{data: 8'h00, stop: 1'b1, div: 16'd0, exp_valid: 1'b1, exp_ferr: 1'b0};
    vecs[5] = '{data: 8'h81, stop: 1'b0, div: 16'd3, exp_valid: 1'b0, exp_ferr: 1'b1};

    wait_clks(3);
    chk("reset m_data", 32'(bus.m_data), 32'h0);
    chk("reset m_valid", 32'(bus.m_valid), 32'h0);
    chk("reset level", 32'(bus.level), 32'h0);
    chk("reset full", 32'(bus.full), 32'h0);
    chk("reset frame_err", 32'(bus.frame_err), 32'h0);
    chk("reset overrun", 32'(bus.overrun), 32'h0);
    rst_n = 1'b1;
    wait_clks(4);

    // Single frames from the table, each starting from an empty FIFO
    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].data, vecs[v].stop, vecs[v].div);
      chk($sformatf("vec%0d m_valid", v), 32'(bus.m_valid), 32'(vecs[v].exp_valid));
      chk($sformatf("vec%0d level", v), 32'(bus.level), vecs[v].exp_valid ? 32'd1 : 32'd0);
      chk($sformatf("vec%0d frame_err", v), 32'(bus.frame_err), 32'(vecs[v].exp_ferr));
      if (vecs[v].exp_valid) begin
        chk($sformatf("vec%0d m_data", v), 32'(bus.m_data), 32'(vecs[v].data));
        pop_one();
        chk($sformatf("vec%0d popped valid", v), 32'(bus.m_valid), 32'h0);
        chk($sformatf("vec%0d popped level", v), 32'(bus.level), 32'h0);
      end
      if (vecs[v].exp_ferr) begin
        clr_err();
        chk($sformatf("vec%0d err_clr", v), 32'(bus.frame_err), 32'h0);
      end
    end

    // "HI" back to back at baud_div=9 without popping
    send_frame(8'h48, 1'b1, 16'd9);
    send_frame(8'h49, 1'b1, 16'd9);
    chk("HI level", 32'(bus.level), 32'd2);
    chk("HI head", 32'(bus.m_data), 32'h48);
    pop_one();
    chk("HI second", 32'(bus.m_data), 32'h49);
    pop_one();
    chk("HI drained", 32'(bus.m_valid), 32'h0);

    // Start glitch shorter than half a bit must be rejected
    bus.baud_div = 16'd0;
    bus.rx = 1'b0;
    wait_clks(4);
    bus.rx = 1'b1;
    wait_clks(40);
    chk("glitch level", 32'(bus.level), 32'h0);
    chk("glitch frame_err", 32'(bus.frame_err), 32'h0);
    send_frame(8'hC6, 1'b1, 16'd0);
    chk("post-glitch byte", 32'(bus.m_data), 32'hC6);
    pop_one();

    // Overrun: 17 bytes into a 16-deep FIFO
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(i), 1'b1, 16'd0);
    end
    chk("ovr full", 32'(bus.full), 32'h1);
    chk("ovr flag", 32'(bus.overrun), 32'h1);
    chk("ovr level", 32'(bus.level), 32'd16);
    chk("ovr head", 32'(bus.m_data), 32'h00);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain %0d", i), 32'(bus.m_data), 32'(i));
      pop_one();
    end
    chk("drain empty", 32'(bus.m_valid), 32'h0);
    chk("drain full", 32'(bus.full), 32'h0);
    clr_err();
    chk("ovr cleared", 32'(bus.overrun), 32'h0);

    // en dropped mid-frame: partial byte discarded, FIFO kept
    send_frame(8'h5A, 1'b1, 16'd0);
    bus.rx = 1'b0;
    wait_clks(16);
    bus.rx = 1'b1;
    wait_clks(16);
    bus.rx = 1'b0;
    wait_clks(16);
    bus.en = 1'b0;
    wait_clks(4);
    bus.rx = 1'b1;
    wait_clks(8);
    bus.en = 1'b1;
    wait_clks(200);
    chk("en-abort level", 32'(bus.level), 32'd1);
    chk("en-abort head", 32'(bus.m_data), 32'h5A);
    chk("en-abort ferr", 32'(bus.frame_err), 32'h0);

    // Async reset during DATA of a second byte
    send_frame(8'hC3, 1'b1, 16'd0);
    chk("pre-reset level", 32'(bus.level), 32'd2);
    bus.rx = 1'b0;
    wait_clks(16);
    bus.rx = 1'b1;
    wait_clks(20);
    rst_n = 1'b0;
    #1;
    chk("arst m_data", 32'(bus.m_data), 32'h0);
    chk("arst m_valid", 32'(bus.m_valid), 32'h0);
    chk("arst level", 32'(bus.level), 32'h0);
    chk("arst full", 32'(bus.full), 32'h0);
    chk("arst flags", {30'd0, bus.frame_err, bus.overrun}, 32'h0);
    wait_clks(4);
    rst_n = 1'b1;
    wait_clks(20);
    send_frame(8'h3C, 1'b1, 16'd0);
    chk("post-reset level", 32'(bus.level), 32'd1);
    chk("post-reset data", 32'(bus.m_data), 32'h3C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
